// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI4 definitions: burst/response encodings, field types
//               and default request/response channel structs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : none (package)
// ============================================================================
package axi_pkg;

   // Widths of the default channel structs below. An endpoint instantiated
   // with these structs must use the same AddrWidth/DataWidth/IdWidth.
   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned AXI_DATA_W = 64;
   localparam int unsigned AXI_ID_W   = 4;
   localparam int unsigned AXI_USER_W = 1;

   typedef logic [7:0] len_t;
   typedef logic [2:0] size_t;
   typedef logic [1:0] burst_t;
   typedef logic [1:0] resp_t;

   localparam burst_t BURST_FIXED = 2'b00;
   localparam burst_t BURST_INCR  = 2'b01;
   localparam burst_t BURST_WRAP  = 2'b10;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [AXI_ID_W-1:0]   id;
      logic [AXI_ADDR_W-1:0] addr;
      len_t                  len;
      size_t                 size;
      burst_t                burst;
      logic                  lock;
      logic [3:0]            cache;
      logic [2:0]            prot;
      logic [3:0]            qos;
      logic [3:0]            region;
      logic [AXI_USER_W-1:0] user;
   } axi_ax_chan_t;

   typedef struct packed {
      logic [AXI_DATA_W-1:0]   data;
      logic [AXI_DATA_W/8-1:0] strb;
      logic                    last;
      logic [AXI_USER_W-1:0]   user;
   } axi_w_chan_t;

   typedef struct packed {
      logic [AXI_ID_W-1:0]   id;
      resp_t                 resp;
      logic [AXI_USER_W-1:0] user;
   } axi_b_chan_t;

   typedef struct packed {
      logic [AXI_ID_W-1:0]   id;
      logic [AXI_DATA_W-1:0] data;
      resp_t                 resp;
      logic                  last;
      logic [AXI_USER_W-1:0] user;
   } axi_r_chan_t;

   typedef struct packed {
      axi_ax_chan_t aw;
      logic         aw_valid;
      axi_w_chan_t  w;
      logic         w_valid;
      logic         b_ready;
      axi_ax_chan_t ar;
      logic         ar_valid;
      logic         r_ready;
   } axi_req_struct_t;

   typedef struct packed {
      logic        aw_ready;
      logic        w_ready;
      axi_b_chan_t b;
      logic        b_valid;
      logic        ar_ready;
      axi_r_chan_t r;
      logic        r_valid;
   } axi_resp_struct_t;

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr
// Description : Combinational next-beat address for an AXI burst.
//               INCR : (addr aligned down to 2^size) + 2^size
//               FIXED: addr unchanged
//               WRAP : addr unchanged (callers treat WRAP as unsupported)
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : addr_i      in  [AddrWidth-1:0] current beat address
//               size_i      in  size_t          log2 of bytes per beat
//               burst_i     in  burst_t         burst type
//               next_addr_o out [AddrWidth-1:0] address of the following beat
// ============================================================================
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter int unsigned AddrWidth = 32
) (
   input  logic [AddrWidth-1:0] addr_i,
   input  size_t                size_i,
   input  burst_t               burst_i,
   output logic [AddrWidth-1:0] next_addr_o
);

   logic [AddrWidth-1:0] beat_bytes;
   logic [AddrWidth-1:0] aligned_addr;

   always_comb begin
      beat_bytes   = AddrWidth'(1) << size_i;
      // Only the first beat of an INCR burst may be unaligned; every later
      // beat starts on a 2^size boundary.
      aligned_addr = addr_i & ~(beat_bytes - AddrWidth'(1));
      next_addr_o  = addr_i;
      if (burst_i == BURST_INCR) begin
         next_addr_o = aligned_addr + beat_bytes;
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_mem_slv.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_slv
// Description : AXI4 subordinate backed by a word-addressed flop memory.
//               Serves single-beat and burst reads/writes strictly one
//               transaction at a time (no outstanding, no interleaving).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk_i       in  1       clock, rising edge
//               rst_ni      in  1       asynchronous reset, active low
//               slv_req_i   in  struct  AXI4 request from the master
//               slv_resp_o  out struct  AXI4 response to the master
// ============================================================================
module axi_mem_slv
   import axi_pkg::*;
#(
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned IdWidth    = 4,
   parameter int unsigned NumWords   = 1024,
   parameter type         axi_req_t  = axi_pkg::axi_req_struct_t,
   parameter type         axi_resp_t = axi_pkg::axi_resp_struct_t
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  axi_req_t  slv_req_i,
   output axi_resp_t slv_resp_o
);

   localparam int unsigned STRB_W = DataWidth / 8;
   localparam int unsigned OFFS_W = $clog2(STRB_W);
   localparam int unsigned IDX_W  = (NumWords > 1) ? $clog2(NumWords) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_WRESP = 2'd2,
      ST_RDATA = 2'd3
   } state_e;

   state_e               state_q,   state_d;
   logic                 active_q,  active_d;
   logic                 rd_prio_q, rd_prio_d;
   logic [IdWidth-1:0]   id_q,      id_d;
   logic [AddrWidth-1:0] addr_q,    addr_d;
   len_t                 len_q,     len_d;
   size_t                size_q,    size_d;
   burst_t               burst_q,   burst_d;
   len_t                 cnt_q,     cnt_d;
   logic                 err_q,     err_d;

   logic [DataWidth-1:0] mem_q [NumWords];

   logic [AddrWidth-1:0] next_addr;
   logic [AddrWidth-1:0] word_idx;
   logic [IDX_W-1:0]     mem_idx;
   logic                 beat_oor;
   logic                 last_beat;
   logic                 grant_w, grant_r;
   logic                 aw_ready, ar_ready, w_ready, b_valid, r_valid;
   logic                 mem_we;

   axi_burst_addr #(
      .AddrWidth (AddrWidth)
   ) u_burst_addr (
      .addr_i      (addr_q),
      .size_i      (size_q),
      .burst_i     (burst_q),
      .next_addr_o (next_addr)
   );

   // WRAP bursts and beats wider than the bus poison every beat, so they are
   // folded into the same out-of-range flag as an over-large index.
   assign word_idx  = addr_q >> OFFS_W;
   assign mem_idx   = word_idx[IDX_W-1:0];
   assign beat_oor  = (burst_q == BURST_WRAP) || (size_q > size_t'(OFFS_W)) ||
                      (word_idx >= AddrWidth'(NumWords));
   assign last_beat = (cnt_q == len_q);

   // Arbitration: a lone valid always wins; on a tie the pointer decides and
   // flips, so back-to-back contention alternates between write and read.
   assign grant_w = slv_req_i.aw_valid && (!slv_req_i.ar_valid || !rd_prio_q);
   assign grant_r = slv_req_i.ar_valid && !grant_w;

   always_comb begin
      state_d   = state_q;
      active_d  = 1'b1;
      rd_prio_d = rd_prio_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      burst_d   = burst_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      aw_ready  = 1'b0;
      ar_ready  = 1'b0;
      w_ready   = 1'b0;
      b_valid   = 1'b0;
      r_valid   = 1'b0;
      mem_we    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // active_q keeps both readies low while reset is asserted.
            if (active_q) begin
               aw_ready = grant_w;
               ar_ready = grant_r;
               if (slv_req_i.aw_valid && slv_req_i.ar_valid) begin
                  rd_prio_d = ~rd_prio_q;
               end
               if (grant_w) begin
                  id_d    = slv_req_i.aw.id;
                  addr_d  = slv_req_i.aw.addr;
                  len_d   = slv_req_i.aw.len;
                  size_d  = slv_req_i.aw.size;
                  burst_d = slv_req_i.aw.burst;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  state_d = ST_WDATA;
               end else if (grant_r) begin
                  id_d    = slv_req_i.ar.id;
                  addr_d  = slv_req_i.ar.addr;
                  len_d   = slv_req_i.ar.len;
                  size_d  = slv_req_i.ar.size;
                  burst_d = slv_req_i.ar.burst;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  state_d = ST_RDATA;
               end
            end
         end
         ST_WDATA: begin
            w_ready = 1'b1;
            if (slv_req_i.w_valid) begin
               mem_we = !beat_oor;
               cnt_d  = cnt_q + len_t'(1);
               addr_d = next_addr;
               // A misplaced wlast is an error, but the beat count alone
               // decides when the burst ends.
               err_d  = err_q || beat_oor || (slv_req_i.w.last != last_beat);
               if (last_beat) begin
                  state_d = ST_WRESP;
               end
            end
         end
         ST_WRESP: begin
            b_valid = 1'b1;
            if (slv_req_i.b_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_RDATA: begin
            r_valid = 1'b1;
            if (slv_req_i.r_ready) begin
               cnt_d  = cnt_q + len_t'(1);
               addr_d = next_addr;
               if (last_beat) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         active_q  <= 1'b0;
         rd_prio_q <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= BURST_FIXED;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         rd_prio_q <= rd_prio_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   // Storage is deliberately left out of reset so a partial burst that is
   // cut short by reset keeps the beats already written.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int unsigned lane = 0; lane < STRB_W; lane++) begin
            if (slv_req_i.w.strb[lane]) begin
               mem_q[mem_idx][lane*8 +: 8] <= slv_req_i.w.data[lane*8 +: 8];
            end
         end
      end
   end

   // Payloads are forced to zero outside their response states; while an R
   // beat is stalled the address, and therefore the data, cannot change.
   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = aw_ready;
      slv_resp_o.ar_ready = ar_ready;
      slv_resp_o.w_ready  = w_ready;
      slv_resp_o.b_valid  = b_valid;
      slv_resp_o.r_valid  = r_valid;
      if (b_valid) begin
         slv_resp_o.b.id   = id_q;
         slv_resp_o.b.resp = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      if (r_valid) begin
         slv_resp_o.r.id   = id_q;
         slv_resp_o.r.data = beat_oor ? '0 : mem_q[mem_idx];
         slv_resp_o.r.resp = beat_oor ? RESP_SLVERR : RESP_OKAY;
         slv_resp_o.r.last = last_beat;
      end
   end

   // Sideband fields carry no meaning for this memory.
   logic unused_fields;
   assign unused_fields = ^{slv_req_i.aw.lock, slv_req_i.aw.cache, slv_req_i.aw.prot,
                            slv_req_i.aw.qos, slv_req_i.aw.region, slv_req_i.aw.user,
                            slv_req_i.ar.lock, slv_req_i.ar.cache, slv_req_i.ar.prot,
                            slv_req_i.ar.qos, slv_req_i.ar.region, slv_req_i.ar.user,
                            slv_req_i.w.user};

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slv.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_mem_slv
// Description : Self-checking bench for axi_mem_slv. A reference memory and
//               B/R expectation queues are filled when stimulus is driven and
//               drained as the DUT responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mem_slv;
   import axi_pkg::*;

   localparam int NUM_WORDS = 1024;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } exp_b_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } exp_r_t;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   axi_req_struct_t  req;
   axi_resp_struct_t resp;

   int errors = 0;
   int checks = 0;

   logic [63:0] model_mem [NUM_WORDS];
   logic [63:0] wdata_buf [16];
   logic [7:0]  wstrb_buf [16];
   exp_b_t      exp_b_q [$];
   exp_r_t      exp_r_q [$];

   always #5 clk = ~clk;

   axi_mem_slv #(
      .AddrWidth  (32),
      .DataWidth  (64),
      .IdWidth    (4),
      .NumWords   (NUM_WORDS),
      .axi_req_t  (axi_req_struct_t),
      .axi_resp_t (axi_resp_struct_t)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .slv_req_i  (req),
      .slv_resp_o (resp)
   );

   // No AW/AR ready while a transaction is in flight, never both at once.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (resp.w_ready || resp.b_valid || resp.r_valid ||
                             resp.aw_ready || resp.ar_ready)) begin
         checks++;
         if ((resp.aw_ready && resp.ar_ready) ||
             ((resp.w_ready || resp.b_valid || resp.r_valid) && (resp.aw_ready || resp.ar_ready))) begin
            errors++;
            $display("FAIL busy_ready t=%0t: aw_ready=%b ar_ready=%b w_ready=%b b_valid=%b r_valid=%b, required no ax ready while busy",
                     $time, resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] beat_addr(input logic [31:0] base, input int beat);
      if (beat == 0) return base;
      return (base & 32'hFFFF_FFF8) + 32'(8 * beat);
   endfunction

   task automatic apply_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic push_write_exp(input logic [31:0] addr, input int len, input logic [3:0] id);
      logic        err;
      logic [31:0] a;
      int          idx;
      err = 1'b0;
      for (int i = 0; i <= len; i++) begin
         a   = beat_addr(addr, i);
         idx = int'(a >> 3);
         if (idx >= NUM_WORDS) err = 1'b1;
         else begin
            for (int ln = 0; ln < 8; ln++) begin
               if (wstrb_buf[i][ln]) model_mem[idx][ln*8 +: 8] = wdata_buf[i][ln*8 +: 8];
            end
         end
      end
      exp_b_q.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
   endtask

   task automatic push_read_exp(input logic [31:0] addr, input int len, input logic [3:0] id);
      logic [31:0] a;
      int          idx;
      exp_r_t      e;
      for (int i = 0; i <= len; i++) begin
         a      = beat_addr(addr, i);
         idx    = int'(a >> 3);
         e.id   = id;
         e.last = (i == len);
         if (idx >= NUM_WORDS) begin
            e.data = 64'h0;
            e.resp = 2'b10;
         end else begin
            e.data = model_mem[idx];
            e.resp = 2'b00;
         end
         exp_r_q.push_back(e);
      end
   endtask

   task automatic set_aw(input logic [31:0] addr, input int len, input logic [3:0] id);
      req.aw       = '0;
      req.aw.id    = id;
      req.aw.addr  = addr;
      req.aw.len   = 8'(len);
      req.aw.size  = 3'd3;
      req.aw.burst = BURST_INCR;
   endtask

   task automatic set_ar(input logic [31:0] addr, input int len, input logic [3:0] id);
      req.ar       = '0;
      req.ar.id    = id;
      req.ar.addr  = addr;
      req.ar.len   = 8'(len);
      req.ar.size  = 3'd3;
      req.ar.burst = BURST_INCR;
   endtask

   task automatic drive_aw(input logic [31:0] addr, input int len, input logic [3:0] id);
      int n;
      set_aw(addr, len, id);
      req.aw_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (resp.aw_ready !== 1'b1 && n < 50);
      checks++;
      if (resp.aw_ready !== 1'b1) begin
         errors++;
         $display("FAIL aw_handshake: aw_ready=%b after %0d cycles, required 1", resp.aw_ready, n);
      end
      @(posedge clk); #1 req.aw_valid = 1'b0;
   endtask

   task automatic drive_ar(input logic [31:0] addr, input int len, input logic [3:0] id);
      int n;
      set_ar(addr, len, id);
      req.ar_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (resp.ar_ready !== 1'b1 && n < 50);
      checks++;
      if (resp.ar_ready !== 1'b1) begin
         errors++;
         $display("FAIL ar_handshake: ar_ready=%b after %0d cycles, required 1", resp.ar_ready, n);
      end
      @(posedge clk); #1 req.ar_valid = 1'b0;
   endtask

   task automatic drive_w(input int nbeats, input int len);
      int n;
      for (int i = 0; i < nbeats; i++) begin
         req.w.data  = wdata_buf[i];
         req.w.strb  = wstrb_buf[i];
         req.w.last  = (i == len);
         req.w_valid = 1'b1;
         n = 0;
         do begin @(negedge clk); n++; end while (resp.w_ready !== 1'b1 && n < 50);
         checks++;
         if (resp.w_ready !== 1'b1) begin
            errors++;
            $display("FAIL w_handshake beat %0d: w_ready=%b, required 1", i, resp.w_ready);
         end
         @(posedge clk); #1;
      end
      req.w_valid = 1'b0;
   endtask

   task automatic wait_b;
      exp_b_t e;
      int     n;
      n = 0;
      do begin @(negedge clk); n++; end while (resp.b_valid !== 1'b1 && n < 50);
      checks++;
      if (resp.b_valid !== 1'b1) begin
         errors++;
         $display("FAIL b_timeout: b_valid=%b, required 1", resp.b_valid);
      end else if (exp_b_q.size() == 0) begin
         errors++;
         $display("FAIL b_unexpected: got id=%h resp=%b, required no response", resp.b.id, resp.b.resp);
      end else begin
         e = exp_b_q.pop_front();
         if ({resp.b.id, resp.b.resp} !== e) begin
            errors++;
            $display("FAIL b_resp: got id=%h resp=%b, required id=%h resp=%b",
                     resp.b.id, resp.b.resp, e.id, e.resp);
         end
         checks++;
         if (n != 1) begin
            errors++;
            $display("FAIL b_latency: b_valid after %0d cycles, required 1", n);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic collect_r(input int len, input bit toggle);
      exp_r_t e, act;
      int     n, beats;
      n = 0;
      beats = 0;
      req.r_ready = toggle ? 1'b0 : 1'b1;
      while (beats <= len && n < 100) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            checks++;
            if (resp.r_valid !== 1'b1) begin
               errors++;
               $display("FAIL r_latency: r_valid=%b one cycle after AR, required 1", resp.r_valid);
            end
         end
         if (resp.r_valid === 1'b1) begin
            checks++;
            act = '{id: resp.r.id, data: resp.r.data, resp: resp.r.resp, last: resp.r.last};
            if (exp_r_q.size() == 0) begin
               errors++;
               $display("FAIL r_unexpected: got %h, required no beat", act);
            end else begin
               e = exp_r_q[0];
               if (act !== e) begin
                  errors++;
                  $display("FAIL r_beat %0d (r_ready=%b): got id=%h data=%h resp=%b last=%b, required id=%h data=%h resp=%b last=%b",
                           beats, req.r_ready, act.id, act.data, act.resp, act.last,
                           e.id, e.data, e.resp, e.last);
               end
               if (req.r_ready) begin
                  void'(exp_r_q.pop_front());
                  beats++;
               end
            end
         end
         @(posedge clk); #1;
         if (toggle) req.r_ready = ~req.r_ready;
      end
      checks++;
      if (beats != len + 1) begin
         errors++;
         $display("FAIL r_count: got %0d beats, required %0d", beats, len + 1);
      end
      req.r_ready = 1'b1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] id);
      push_write_exp(addr, len, id);
      drive_aw(addr, len, id);
      drive_w(len + 1, len);
      wait_b();
   endtask

   task automatic axi_read(input logic [31:0] addr, input int len, input logic [3:0] id, input bit toggle);
      push_read_exp(addr, len, id);
      drive_ar(addr, len, id);
      collect_r(len, toggle);
   endtask

   task automatic test_reset;
      req          = '0;
      req.b_ready  = 1'b1;
      req.r_ready  = 1'b1;
      req.aw_valid = 1'b1;
      req.ar_valid = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (resp !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, required all zero", resp);
      end
      req.aw_valid = 1'b0;
      req.ar_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (resp !== '0) begin
         errors++;
         $display("FAIL idle_outputs: got %h, required all zero", resp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      wdata_buf[0] = 64'hA5A5_A5A5_A5A5_A5A5;
      wstrb_buf[0] = 8'hFF;
      axi_write(32'h10, 0, 4'h3);
      axi_read(32'h10, 0, 4'h5, 1'b0);
   endtask

   task automatic test_incr_burst;
      for (int i = 0; i < 4; i++) begin
         wdata_buf[i] = 64'(i + 1);
         wstrb_buf[i] = 8'hFF;
      end
      axi_write(32'h0, 3, 4'h1);
      axi_read(32'h0, 3, 4'h2, 1'b1);
   endtask

   task automatic test_strobes;
      wdata_buf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      wstrb_buf[0] = 8'hFF;
      axi_write(32'h28, 0, 4'h4);
      wdata_buf[0] = 64'h0;
      wstrb_buf[0] = 8'h0F;
      axi_write(32'h28, 0, 4'h4);
      axi_read(32'h28, 0, 4'h6, 1'b0);
   endtask

   task automatic test_out_of_range;
      wdata_buf[0] = 64'h1111_1111_1111_1111;
      wdata_buf[1] = 64'h2222_2222_2222_2222;
      wstrb_buf[0] = 8'hFF;
      wstrb_buf[1] = 8'hFF;
      axi_write(32'h1FF8, 1, 4'h7);
      axi_read(32'h1FF8, 1, 4'hE, 1'b0);
   endtask

   task automatic test_arbitration;
      apply_reset();
      // Round 1: tie straight after reset goes to the write.
      wdata_buf[0] = 64'h0123_4567_89AB_CDEF;
      wstrb_buf[0] = 8'hFF;
      push_write_exp(32'h100, 0, 4'h8);
      push_read_exp(32'h100, 0, 4'h9);
      set_ar(32'h100, 0, 4'h9);
      set_aw(32'h100, 0, 4'h8);
      req.ar_valid = 1'b1;
      req.aw_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({resp.aw_ready, resp.ar_ready} !== 2'b10) begin
         errors++;
         $display("FAIL arb_first_write: aw_ready=%b ar_ready=%b, required 1 0", resp.aw_ready, resp.ar_ready);
      end
      @(posedge clk); #1 req.aw_valid = 1'b0;
      drive_w(1, 0);
      wait_b();
      drive_ar(32'h100, 0, 4'h9);
      collect_r(0, 1'b0);
      // Round 2: the next tie goes to the read.
      wdata_buf[0] = 64'hFEDC_BA98_7654_3210;
      push_read_exp(32'h100, 0, 4'hA);
      push_write_exp(32'h100, 0, 4'hB);
      set_ar(32'h100, 0, 4'hA);
      set_aw(32'h100, 0, 4'hB);
      req.ar_valid = 1'b1;
      req.aw_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({resp.aw_ready, resp.ar_ready} !== 2'b01) begin
         errors++;
         $display("FAIL arb_first_read: aw_ready=%b ar_ready=%b, required 0 1", resp.aw_ready, resp.ar_ready);
      end
      @(posedge clk); #1 req.ar_valid = 1'b0;
      collect_r(0, 1'b0);
      drive_aw(32'h100, 0, 4'hB);
      drive_w(1, 0);
      wait_b();
      axi_read(32'h100, 0, 4'hC, 1'b0);
   endtask

   task automatic test_reset_mid_burst;
      wdata_buf[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      wdata_buf[1] = 64'hBBBB_BBBB_BBBB_BBBB;
      wdata_buf[2] = 64'hCCCC_CCCC_CCCC_CCCC;
      wdata_buf[3] = 64'hDDDD_DDDD_DDDD_DDDD;
      for (int i = 0; i < 4; i++) wstrb_buf[i] = 8'hFF;
      model_mem[0] = wdata_buf[0];
      model_mem[1] = wdata_buf[1];
      drive_aw(32'h0, 3, 4'h2);
      drive_w(2, 3);
      req.w.data  = wdata_buf[2];
      req.w.strb  = 8'hFF;
      req.w.last  = 1'b0;
      req.w_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_async: aw_ready=%b w_ready=%b ar_ready=%b b_valid=%b r_valid=%b, required all 0",
                  resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid);
      end
      req.w_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      axi_read(32'h0, 3, 4'h1, 1'b0);
      wdata_buf[0] = 64'h5555_6666_7777_8888;
      wstrb_buf[0] = 8'hFF;
      axi_write(32'h40, 0, 4'h6);
      axi_read(32'h40, 0, 4'hD, 1'b0);
   endtask

   initial begin
      req         = '0;
      req.b_ready = 1'b1;
      req.r_ready = 1'b1;
      test_reset();
      test_single();
      test_incr_burst();
      test_strobes();
      test_out_of_range();
      test_arbitration();
      test_reset_mid_burst();
      checks++;
      if (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d B and %0d R expectations left, required 0 and 0",
                  exp_b_q.size(), exp_r_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
